fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DBIT, default 8, meaning data bits per frame; equals the FIFO word width.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port empty  input  1  FIFO empty flag from the upstream FIFO read side.
REQ-006 SHALL have port r_data  input  DBIT  FIFO head word, valid while empty=0 (first-word-fall-through).
REQ-007 SHALL have port rd  output  1  FIFO pop strobe; the FIFO advances one word per high cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-009 SHALL have port tx_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port tx_done_tick  output  1  one-cycle pulse at end of each frame.
REQ-011 SHALL use one clock only (clk); reset is asynchronous and active-high.

Function
REQ-012 SHALL implement states IDLE, LOAD, START, DATA, PARITY (PARITY_EN only), STOP.
REQ-013 IDLE: tx=1, rd=0; on an edge with empty=0, go to LOAD; with empty=1, stay.
REQ-014 LOAD (exactly one cycle): rd=1, shift register <= r_data, bit counter <= 0, tick counter <= 0; next state START.
REQ-015 rd SHALL be high only in LOAD, so exactly one pop per frame, never while empty=1 at the IDLE sample.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles; then DATA.
REQ-017 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first; shift right after each bit; after DBIT bits, go to PARITY if enabled, else STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done_tick=1 on the last STOP cycle; next state IDLE.
REQ-019 tx SHALL be driven from a register (no combinational glitch); tx transitions align with state/bit boundaries.
REQ-020 The tick counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; the bit counter SHALL be ceil(log2(DBIT+1)) bits wide.
REQ-021 Back-to-back frames: with empty=0 at the end of STOP, the gap between the STOP end and the next START SHALL be exactly 2 cycles of tx=1 (IDLE + LOAD).
REQ-022 Changes on empty or r_data outside LOAD SHALL NOT affect the frame in progress.
REQ-023 Frame length SHALL be (DBIT+2)*CLKS_PER_BIT cycles, or (DBIT+3)*CLKS_PER_BIT with PARITY_EN.

Reset
REQ-024 On reset assertion, immediately: state=IDLE, tx=1, rd=0, tx_busy=0, tx_done_tick=0, counters=0, shift register=0.
REQ-025 Reset mid-frame SHALL abort the frame without a done pulse; the already-popped word is discarded (not re-read).
REQ-026 After reset deasserts, the first frame SHALL start only via IDLE->LOAD with empty=0.

Configuration
REQ-027 Macro FIFO_UART_TX_PARITY_EN: when defined, SHALL insert one PARITY bit of CLKS_PER_BIT cycles between DATA and STOP, with value equal to the XOR of the DBIT data bits (even parity).
REQ-028 Without FIFO_UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4, DBIT=8)
REQ-029 Reset held, empty=0 -> rd=0, tx=1, tx_busy=0 throughout; no pop.
REQ-030 Single word 0x14, empty falls -> one rd pulse; tx = 0(4 cyc), then bits 0,0,1,0,1,0,0,0 (4 cyc each), then 1(4 cyc); tx_done_tick once; 40 cycles START-to-STOP-end.
REQ-031 Eight words 0x14,0x0A,0x0C,0x0B,0x09,0x08,0x07,0x06 queued -> eight frames in order, exactly 8 rd pulses, 2-cycle idle gap between frames, tx_busy drops after the last frame.
REQ-032 PARITY_EN, word 0x07 -> parity bit 1, frame 44 cycles; word 0x14 -> parity bit 0.
REQ-033 Reset asserted at DATA bit 3 of 0x14 -> tx=1 immediately, no tx_done_tick; next queued word transmits cleanly after release.
REQ-034 empty toggling during DATA -> no extra rd pulse, frame bits unchanged.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that drains a first-word-fall-through FIFO.
// Each frame pops one word and sends a start bit, DBIT data bits LSB first,
// and one stop bit.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DBIT         = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DBIT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd5
`ifdef FIFO_UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            tick_last_s;
  logic            bit_last_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign tick_last_s = (tick_q == TICK_LAST);
  assign bit_last_s  = (bit_q == BIT_LAST);

  // State register: reset forces IDLE at once, aborting any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk the frame one bit period at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_LOAD;
        else        state_d = S_IDLE;
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        if (tick_last_s) state_d = S_DATA;
        else             state_d = S_START;
      end
      S_DATA: begin
        if (tick_last_s && bit_last_s) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_last_s) state_d = S_STOP;
        else             state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (tick_last_s) state_d = S_IDLE;
        else             state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture the FIFO head in LOAD only, then count
  // ticks per bit and shift the data right at each data-bit boundary.
  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_LOAD: begin
        tick_d  = {TW{1'b0}};
        bit_d   = {BW{1'b0}};
        shift_d = r_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^r_data;
`endif
      end
      S_START, S_STOP: begin
        if (tick_last_s) tick_d = {TW{1'b0}};
        else             tick_d = tick_q + TW'(1);
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_last_s) tick_d = {TW{1'b0}};
        else             tick_d = tick_q + TW'(1);
      end
`endif
      S_DATA: begin
        if (tick_last_s) begin
          tick_d  = {TW{1'b0}};
          bit_d   = bit_q + BW'(1);
          shift_d = {1'b0, shift_q[DBIT-1:1]};
        end else begin
          tick_d  = tick_q + TW'(1);
        end
      end
      default: begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
      end
    endcase
  end

  // Output logic: tx is precomputed from the next state so the line
  // register changes exactly on state/bit boundaries.
  always_comb begin
    tx_d         = 1'b1;
    rd           = 1'b0;
    tx_busy      = 1'b0;
    tx_done_tick = 1'b0;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    rd           = (state_q == S_LOAD);
    tx_busy      = (state_q != S_IDLE);
    tx_done_tick = (state_q == S_STOP) && tick_last_s;
  end

  // Datapath and line registers: everything returns to zero / idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q  <= {TW{1'b0}};
      bit_q   <= {BW{1'b0}};
      shift_q <= {DBIT{1'b0}};
      tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx = tx_q;

endmodule
